// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache, single-word fills
// Optional hit/miss counters under `ICACHE_STATS_EN.
module icache_responder #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state, next_state;
  logic [29:0]        miss_addr;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tag_arr  [SETS];
  logic [31:0]        data_arr [SETS];

  logic [IDX_W-1:0]   req_idx, miss_idx;
  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic               lookup_hit;
  logic               start_miss;
  logic               fill_done;
  logic               unused_byte_bits;

  assign req_idx          = imemaddr[IDX_W+1:2];
  assign req_tag          = imemaddr[31:IDX_W+2];
  assign miss_idx         = miss_addr[IDX_W-1:0];
  assign miss_tag         = miss_addr[29:IDX_W];
  assign lookup_hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign unused_byte_bits = ^imemaddr[1:0];

  // Outputs are fully decoded from state so iREN drops as soon as reset hits.
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'd0;
    iREN       = 1'b0;
    iaddr      = 32'd0;
    start_miss = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_arr[req_idx];
          end else begin
            start_miss = 1'b1;
            next_state = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {miss_addr, 2'b00};
        if (!iwait) begin
          fill_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 30'd0;
      valid     <= '0;
    end else begin
      state <= next_state;
      if (start_miss) begin
        miss_addr <= imemaddr[31:2];
      end
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[miss_idx]  <= miss_tag;
      data_arr[miss_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_miss && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - randomized self-checking bench for icache_responder
// Build with ICACHE_STATS_EN defined to exercise the counters as well.
module tb_icache_responder;

  localparam int SETS = 16;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_responder #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which word address each frame holds, plus event counts.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] w;
    if (addr[31:2] == 30'h10) return 32'h00A0_0093;
    w = {2'b00, addr[31:2]};
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int frame_of(input logic [31:0] addr);
    return int'((addr >> 2) % SETS);
  endfunction

  function automatic bit m_hit(input logic [31:0] addr);
    return m_valid[frame_of(addr)] && (m_word[frame_of(addr)] == addr[31:2]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    iwait    = 1'b1;
    iload    = 32'd0;
    model_clear();
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    @(posedge CLK); #1;
    nRST    = 1'b1;
    imemREN = 1'b0;
  endtask

  // One request; on a miss, serves the fill after `waits` busy cycles.
  task automatic do_req(input logic [31:0] addr, input int waits,
                        input bit use_alt, input logic [31:0] alt);
    bit          exp_hit;
    logic [31:0] exp_data;
    exp_hit  = m_hit(addr);
    exp_data = mem_word(addr);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = $urandom;
    @(negedge CLK);
    chk("req_ihit", {31'd0, ihit}, {31'd0, exp_hit});
    chk("req_iren", {31'd0, iREN}, 32'd0);
    chk("req_imemload", imemload, exp_hit ? exp_data : 32'd0);
    @(posedge CLK); #1;
    if (exp_hit) begin
      m_hits++;
    end else begin
      m_misses++;
      for (int j = 0; j <= waits; j++) begin
        iwait    = (j < waits);
        iload    = (j == waits) ? exp_data : $urandom;
        imemaddr = use_alt ? alt : $urandom;
        imemREN  = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("fill_iren", {31'd0, iREN}, 32'd1);
        chk("fill_iaddr", iaddr, {addr[31:2], 2'b00});
        chk("fill_ihit", {31'd0, ihit}, 32'd0);
        @(posedge CLK); #1;
      end
      iwait    = 1'b1;
      imemaddr = addr;
      imemREN  = 1'b1;
      m_valid[frame_of(addr)] = 1'b1;
      m_word[frame_of(addr)]  = addr[31:2];
      m_hits++;
      @(negedge CLK);
      chk("post_ihit", {31'd0, ihit}, 32'd1);
      chk("post_imemload", imemload, exp_data);
      chk("post_iren", {31'd0, iREN}, 32'd0);
      @(posedge CLK); #1;
    end
    imemREN = 1'b0;
  endtask

  task automatic idle_cycle();
    imemREN  = 1'b0;
    imemaddr = $urandom;
    @(negedge CLK);
    chk("idle_ihit", {31'd0, ihit}, 32'd0);
    chk("idle_imemload", imemload, 32'd0);
    chk("idle_iren", {31'd0, iREN}, 32'd0);
    chk("idle_iaddr", iaddr, 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [31:0] a;
    do_reset();

    // Cold miss with 3 wait cycles, then warm hit.
    do_req(32'h0000_0040, 3, 1'b0, 32'd0);
    do_req(32'h0000_0040, 0, 1'b0, 32'd0);

    // Conflict eviction on frame 0.
    do_req(32'h0000_0080, 1, 1'b0, 32'd0);
    do_req(32'h0000_0040, 2, 1'b0, 32'd0);

    // Address change during fill is ignored.
    do_req(32'h0000_0100, 2, 1'b1, 32'h0000_0200);
    do_req(32'h0000_0100, 0, 1'b0, 32'd0);
    do_req(32'h0000_0200, 0, 1'b0, 32'd0);
    idle_cycle();

    // Reset during fill.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0300;
    iwait    = 1'b1;
    @(negedge CLK);
    chk("rf_req_ihit", {31'd0, ihit}, 32'd0);
    @(posedge CLK); #1;
    imemaddr = 32'h0000_0040;
    @(negedge CLK);
    chk("rf_fill_iren", {31'd0, iREN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rf_async_iren", {31'd0, iREN}, 32'd0);
    chk("rf_async_iaddr", iaddr, 32'd0);
    model_clear();
    @(posedge CLK); #1;
    nRST    = 1'b1;
    imemREN = 1'b0;
    do_req(32'h0000_0300, 1, 1'b0, 32'd0);
    do_req(32'h0000_0200, 0, 1'b0, 32'd0);

    // Two misses and five hits from a clean reset.
    do_reset();
    do_req(32'h0000_0040, 1, 1'b0, 32'd0);
    do_req(32'h0000_0040, 0, 1'b0, 32'd0);
    do_req(32'h0000_0044, 2, 1'b0, 32'd0);
    do_req(32'h0000_0044, 0, 1'b0, 32'd0);
    do_req(32'h0000_0040, 0, 1'b0, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("stats_miss_count", miss_count, 32'd2);
    chk("stats_hit_count", hit_count, 32'd5);
`endif

    // Randomized traffic over a small address pool so frames collide often.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0000_0000;
        a = a | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        do_req(a, $urandom_range(0, 4), 1'b0, 32'd0);
      end
    end
`ifdef ICACHE_STATS_EN
    chk("rand_miss_count", miss_count, m_misses);
    chk("rand_hit_count", hit_count, m_hits);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
# icache_responder

Direct-mapped, read-only instruction cache that serves the pipeline's fetch port. It answers `imemREN`/`imemaddr` requests with `ihit`/`imemload`. On a miss it issues a single-word read to the memory controller through `iREN`/`iaddr`/`iwait`/`iload`. It sits between the datapath fetch stage and the cache/memory controller, and is the responder for the datapath's instruction-side requests.

## Interface
Parameters:
- `SETS`, default 16: number of one-word frames; power of two, 2..1024. `IDX_W = log2(SETS)`, `TAG_W = 30 - IDX_W`.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  reset, asynchronous and active-low.
- `imemREN`  in  1  datapath instruction read request.
- `imemaddr`  in  32  byte address; bits [1:0] ignored; index = [IDX_W+1:2], tag = [31:IDX_W+2].
- `ihit`  out  1  requested word valid this cycle.
- `imemload`  out  32  instruction word; meaningful only when `ihit`=1.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address, with [1:0]=00.
- `iwait`  in  1  memory busy; data is valid in the cycle `iwait`=0 while `iREN`=1.
- `iload`  in  32  memory read data.

## Operation
- Storage per frame: `valid`, tag[TAG_W], data[32]. All `valid` bits are cleared on reset. Data and tag arrays are not reset.
- FSM states:
  - IDLE: `iREN`=0. `ihit = imemREN & valid[idx] & (tag[idx]==addr tag)`, combinational. `imemload = data[idx]`.
    - If `imemREN` and no hit: latch `{tag,idx}` into `miss_addr` and go to FILL.
  - FILL: `iREN`=1, `iaddr = {miss_addr,2'b00}`, `ihit`=0.
    - On a cycle with `iwait`=0: write `iload` into `data[miss idx]`, write `miss tag` into the tag array, set `valid`, then return to IDLE.
- Fill uses the latched address. Changes to `imemaddr` or `imemREN` during FILL are ignored, and the fill always completes.
- A conflicting address overwrites the frame (no replacement choice).
- `imemREN`=0 in IDLE: `ihit`=0, no state change.
- No write path; instruction memory is treated as immutable.

## Timing
- Reset values: `ihit`=0, `imemload`=0 (forced to 0 while `ihit`=0), `iREN`=0, `iaddr`=0. State is IDLE and all frames are invalid.
- Hit: zero-cycle latency, with `ihit` asserted in the same cycle as the request.
- Miss on request cycle T: FILL from T+1. If memory drops `iwait` in cycle T+1+k, the frame is written at the end of that cycle. State is IDLE at T+2+k, and `ihit`=1 at T+2+k if the address is held.
- Miss penalty is therefore k+2 cycles for a memory latency of k wait cycles.
- `ihit` is never asserted in FILL, including the fill-completion cycle.
- `nRST` asserted mid-FILL: FSM returns to IDLE immediately and `iREN` drops asynchronously. The pending fill is discarded and all valid bits are cleared.
- Index wrap: addresses differing by `SETS*4` map to the same frame and evict each other.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` (out, 32) and `miss_count` (out, 32), both reset to 0.
  - `hit_count` increments on every IDLE cycle with `ihit`=1.
  - `miss_count` increments on every IDLE→FILL transition.
  - Both counters saturate at 32'hFFFF_FFFF.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Cold miss: reset, then `imemREN`=1, `imemaddr`=0x0000_0040, memory holds 0x00A0_0093 with 3 wait cycles.
  - Required: `iREN`=1 and `iaddr`=0x40 for 4 cycles.
  - Required: `ihit`=1 with `imemload`=0x00A0_0093 in the following cycle, with `ihit`=0 throughout FILL.
- Warm hit: immediately re-request 0x40 → `ihit`=1 in the same cycle, `iREN` stays 0.
- Conflict eviction (`SETS`=16): fill 0x40, then request 0x80 (same index 0, different tag).
  - Required: a miss with `iaddr`=0x80.
  - Required: a re-request of 0x40 misses again.
- Address change mid-fill: miss on 0x100, then switch `imemaddr` to 0x200 during FILL.
  - Required: `iaddr` stays 0x100 and frame 0 holds the 0x100 tag.
  - Required: the next request to 0x200 misses.
- Reset mid-fill: assert `nRST`=0 during FILL.
  - Required: `iREN`=0 immediately.
  - Required: after release, a request to the previously filling address misses.
- Stats (macro defined): 2 misses and 5 hits → `miss_count`=2, `hit_count`=5; after reset, both are 0.
